imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : imem_loader
//  Description : Streams instruction words from a valid/ready source into
//                consecutive instruction-memory addresses from a base, holds
//                fetch in stall via busy, and reports an XOR checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          INST_WIDTH = 32,
    parameter logic [31:0] MEM_ID     = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] count,
    input  logic                  in_valid,
    input  logic [INST_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [INST_WIDTH-1:0] mem_wr_data,
    output logic [31:0]           mem_id,
    output logic                  busy,
    output logic                  done,
    output logic [INST_WIDTH-1:0] checksum
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [ADDR_WIDTH-1:0]   remain_q,  remain_d;
    logic [INST_WIDTH-1:0]   csum_q,    csum_d;
    logic                    wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [INST_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    w_xfer;

    assign in_ready = (state_q == S_LOAD) && (remain_q != '0);
    assign w_xfer   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = count;
                    csum_d   = '0;
                    state_d  = (count != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    addr_d    = addr_q + c_ADDR_ONE;
                    remain_d  = remain_q - c_ADDR_ONE;
                    csum_d    = csum_q ^ in_data;
                    if (remain_q == c_ADDR_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // A staged write is masked while reset is high so a mid-load reset cannot leak it.
    assign mem_wr_en   = wr_en_q & ~reset;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign mem_id      = MEM_ID;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign checksum    = csum_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Cycle-by-cycle vector bench for imem_loader with a small
//                write-port memory model for read-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] c_MEM_ID = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h0;
    logic [7:0]  count = 8'h0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_ready;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_id;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    logic [31:0] mem [256] = '{default: 32'h0};

    imem_loader #(
        .ADDR_WIDTH (8),
        .INST_WIDTH (32),
        .MEM_ID     (c_MEM_ID)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_id      (mem_id),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en === 1'b1) begin
            mem[mem_wr_addr] <= mem_wr_data;
            n_writes <= n_writes + 1;
        end
    end

    typedef struct {
        logic        rst;
        logic        st;
        logic [7:0]  base;
        logic [7:0]  cnt;
        logic        vld;
        logic [31:0] data;
        logic        rdy;
        logic        wen;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        cad;
        logic        bsy;
        logic        dn;
        logic [31:0] csum;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst, input logic st, input logic [7:0] base, input logic [7:0] cnt,
        input logic vld, input logic [31:0] data,
        input logic rdy, input logic wen, input logic [7:0] waddr, input logic [31:0] wdata,
        input logic cad, input logic bsy, input logic dn, input logic [31:0] csum);
        vec_t v;
        v.rst = rst; v.st = st; v.base = base; v.cnt = cnt; v.vld = vld; v.data = data;
        v.rdy = rdy; v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.cad = cad;
        v.bsy = bsy; v.dn = dn; v.csum = csum;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d got %h expected %h", nm, row, got, exp);
        end
    endtask

    initial begin
        //         rst st base   cnt   vld data           rdy wen waddr wdata          cad bsy dn csum
        // reset held two cycles with start asserted
        vq.push_back(mk(1, 1, 8'h55, 8'd5, 1, 32'h1234,   0, 0, 8'h00, 32'h0,        1, 0, 0, 32'h0));
        vq.push_back(mk(1, 1, 8'h55, 8'd5, 1, 32'h1234,   0, 0, 8'h00, 32'h0,        1, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 0, 8'h00, 32'h0,        1, 0, 0, 32'h0));
        // basic load: base 0x10, count 3, words A,B,C
        vq.push_back(mk(0, 1, 8'h10, 8'd3, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'hA,      1, 0, 8'h00, 32'h0,        0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'hB,      1, 1, 8'h10, 32'hA,        1, 1, 0, 32'hA));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'hC,      1, 1, 8'h11, 32'hB,        1, 1, 0, 32'h1));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 1, 8'h12, 32'hC,        1, 1, 1, 32'hD));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'hD));
        // bubbles: count 2, valid pattern 1,0,0,1
        vq.push_back(mk(0, 1, 8'h20, 8'd2, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'hD));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'h111,    1, 0, 8'h00, 32'h0,        0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'hDEAD,   1, 1, 8'h20, 32'h111,      1, 1, 0, 32'h111));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'hDEAD,   1, 0, 8'h00, 32'h0,        0, 1, 0, 32'h111));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'h222,    1, 0, 8'h00, 32'h0,        0, 1, 0, 32'h111));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'hDEAD,   0, 1, 8'h21, 32'h222,      1, 1, 1, 32'h333));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h333));
        // count 0: done one cycle after start, no write
        vq.push_back(mk(0, 1, 8'h30, 8'd0, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h333));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'hBAD,    0, 0, 8'h00, 32'h0,        0, 1, 1, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'hBAD,    0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h0));
        // wrap: base 0xFF, count 2
        vq.push_back(mk(0, 1, 8'hFF, 8'd2, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'h5,      1, 0, 8'h00, 32'h0,        0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'h6,      1, 1, 8'hFF, 32'h5,        1, 1, 0, 32'h5));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 1, 8'h00, 32'h6,        1, 1, 1, 32'h3));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h3));
        // reset the cycle after the 2nd transfer of a count-4 load
        vq.push_back(mk(0, 1, 8'h50, 8'd4, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h3));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'h1000,   1, 0, 8'h00, 32'h0,        0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'h2000,   1, 1, 8'h50, 32'h1000,     1, 1, 0, 32'h1000));
        vq.push_back(mk(1, 0, 8'h00, 8'd0, 1, 32'h3000,   1, 0, 8'h00, 32'h0,        0, 1, 0, 32'h3000));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'h4000,   0, 0, 8'h00, 32'h0,        1, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 0, 8'h00, 32'h0,        1, 0, 0, 32'h0));
        // start while busy is ignored; start after done is accepted
        vq.push_back(mk(0, 1, 8'h60, 8'd3, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 8'h40, 8'd1, 1, 32'h7,      1, 0, 8'h00, 32'h0,        0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'h8,      1, 1, 8'h60, 32'h7,        1, 1, 0, 32'h7));
        vq.push_back(mk(0, 1, 8'h40, 8'd1, 1, 32'h9,      1, 1, 8'h61, 32'h8,        1, 1, 0, 32'hF));
        vq.push_back(mk(0, 1, 8'h40, 8'd0, 0, 32'h0,      0, 1, 8'h62, 32'h9,        1, 1, 1, 32'h6));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h6));
        vq.push_back(mk(0, 1, 8'h40, 8'd1, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'h6));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 1, 32'hAB,     1, 0, 8'h00, 32'h0,        0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 1, 8'h40, 32'hAB,       1, 1, 1, 32'hAB));
        vq.push_back(mk(0, 0, 8'h00, 8'd0, 0, 32'h0,      0, 0, 8'h00, 32'h0,        0, 0, 0, 32'hAB));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset     = vq[i].rst;
            start     = vq[i].st;
            base_addr = vq[i].base;
            count     = vq[i].cnt;
            in_valid  = vq[i].vld;
            in_data   = vq[i].data;
            #1;
            chk("in_ready",  i, 32'(in_ready),  32'(vq[i].rdy));
            chk("mem_wr_en", i, 32'(mem_wr_en), 32'(vq[i].wen));
            if (vq[i].cad) begin
                chk("mem_wr_addr", i, 32'(mem_wr_addr), 32'(vq[i].waddr));
                chk("mem_wr_data", i, mem_wr_data,      vq[i].wdata);
            end
            chk("busy",     i, 32'(busy), 32'(vq[i].bsy));
            chk("done",     i, 32'(done), 32'(vq[i].dn));
            chk("checksum", i, checksum,  vq[i].csum);
            chk("mem_id",   i, mem_id,    c_MEM_ID);
        end

        @(negedge clk);
        chk("readback_10", 0, mem[8'h10], 32'hA);
        chk("readback_11", 0, mem[8'h11], 32'hB);
        chk("readback_12", 0, mem[8'h12], 32'hC);
        chk("readback_20", 0, mem[8'h20], 32'h111);
        chk("readback_21", 0, mem[8'h21], 32'h222);
        chk("readback_30", 0, mem[8'h30], 32'h0);
        chk("readback_ff", 0, mem[8'hFF], 32'h5);
        chk("readback_00", 0, mem[8'h00], 32'h6);
        chk("readback_50", 0, mem[8'h50], 32'h1000);
        chk("readback_51", 0, mem[8'h51], 32'h0);
        chk("readback_62", 0, mem[8'h62], 32'h9);
        chk("readback_40", 0, mem[8'h40], 32'hAB);
        chk("write_count", 0, 32'(n_writes), 32'd12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
